// File: rtl/any1_pkg.sv
// Shared ANY-1 memory-unit definitions: load size codes, load-size decode
// and the load-aligner state encoding.
package any1_pkg;

    localparam int DBW = 256;
    localparam int NB  = DBW / 8;

    localparam logic [2:0] LD_SZ_2B    = 3'd0;
    localparam logic [2:0] LD_SZ_4B    = 3'd1;
    localparam logic [2:0] LD_SZ_8B    = 3'd2;
    localparam logic [2:0] LD_SZ_16B   = 3'd3;
    localparam logic [2:0] LD_SZ_32B   = 3'd4;
    localparam logic [2:0] LD_SZ_ILL   = 3'd5;
    localparam logic [2:0] LD_SZ_16B_A = 3'd6;
    localparam logic [2:0] LD_SZ_16B_B = 3'd7;

    typedef enum logic [1:0] {
        LA_IDLE = 2'd0,
        LA_B0   = 2'd1,
        LA_B1   = 2'd2,
        LA_DONE = 2'd3
    } LdAlignState;

    // Byte count of a load; 0 marks the illegal code. Bit 3 (zero-extend) is ignored.
    function automatic logic [5:0] ld_size(input logic [3:0] func);
        logic [5:0] n;
        case (func[2:0])
            LD_SZ_2B:    n = 6'd2;
            LD_SZ_4B:    n = 6'd4;
            LD_SZ_8B:    n = 6'd8;
            LD_SZ_16B:   n = 6'd16;
            LD_SZ_32B:   n = 6'd32;
            LD_SZ_ILL:   n = 6'd0;
            LD_SZ_16B_A: n = 6'd16;
            LD_SZ_16B_B: n = 6'd16;
            default:     n = 6'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/any1_ld_ext.sv
// Shift the two-beat load buffer down to the addressed byte, truncate to the
// load size, then sign- or zero-extend to the full data bus width.
module any1_ld_ext
    import any1_pkg::*;
(
    input  logic [2*DBW-1:0] lbuf_i,
    input  logic [4:0]       adr_i,
    input  logic [3:0]       func_i,
    output logic [DBW-1:0]   result_o
);

    logic [2*DBW-1:0] shifted;
    logic [5:0]       nbytes;
    logic             sign;

    always_comb begin
        shifted  = lbuf_i >> {adr_i, 3'b000};
        nbytes   = ld_size(func_i);
        result_o = '0;
        sign     = 1'b0;
        // A 32 B load has no byte above the top, so the fill loop never fires.
        if (nbytes != 6'd0) begin
            sign = ~func_i[3] & shifted[{nbytes, 3'b000} - 9'd1];
        end
        for (int b = 0; b < NB; b++) begin
            if (6'(b) < nbytes) begin
                result_o[b*8 +: 8] = shifted[b*8 +: 8];
            end else if (sign) begin
                result_o[b*8 +: 8] = 8'hFF;
            end
        end
    end

endmodule

// File: rtl/any1_load_align.sv
// ANY-1 load-return aligner: accepts a load descriptor, collects one or two
// read beats, and returns the aligned, extended result on a valid/ready port.
module any1_load_align
    import any1_pkg::*;
(
    input  logic           rst_i,
    input  logic           clk_i,
    input  logic           req_i,
    output logic           rdy_o,
    input  logic [3:0]     func_i,
    input  logic [4:0]     adr_i,
    output logic [NB-1:0]  sel_o,
    output logic           beat_o,
    input  logic           ack_i,
    input  logic [DBW-1:0] dat_i,
    output logic [DBW-1:0] res_o,
    output logic           res_v_o,
    input  logic           res_rdy_i,
    output logic           err_o
);

    LdAlignState      state_q, state_d;
    logic [3:0]       func_q, func_d;
    logic [4:0]       adr_q, adr_d;
    logic [2*DBW-1:0] lbuf_q, lbuf_d;
    logic [DBW-1:0]   res_q, res_d;
    logic             err_q, err_d;

    logic [63:0]      mask;
    logic             span;
    logic [2*DBW-1:0] beat_buf;
    logic [DBW-1:0]   ext_res;

    always_comb begin
        mask = ((64'd1 << ld_size(func_q)) - 64'd1) << adr_q;
        span = |mask[63:32];
    end

    // Buffer with the current beat merged in, so the result can be registered on the last ack edge.
    always_comb begin
        beat_buf = lbuf_q;
        if (state_q == LA_B0) begin
            beat_buf[DBW-1:0] = dat_i;
        end else if (state_q == LA_B1) begin
            beat_buf[2*DBW-1:DBW] = dat_i;
        end
    end

    any1_ld_ext u_ext (
        .lbuf_i   (beat_buf),
        .adr_i    (adr_q),
        .func_i   (func_q),
        .result_o (ext_res)
    );

    always_comb begin
        state_d = state_q;
        func_d  = func_q;
        adr_d   = adr_q;
        lbuf_d  = lbuf_q;
        res_d   = res_q;
        err_d   = err_q;
        rdy_o   = 1'b0;
        sel_o   = '0;
        beat_o  = 1'b0;
        res_v_o = 1'b0;
        case (state_q)
            LA_IDLE: begin
                rdy_o = 1'b1;
                if (req_i) begin
                    func_d = func_i;
                    adr_d  = adr_i;
                    if (ld_size(func_i) == 6'd0) begin
                        state_d = LA_DONE;
                        res_d   = '0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = LA_B0;
                    end
                end
            end
            LA_B0: begin
                sel_o = mask[31:0];
                if (ack_i) begin
                    lbuf_d = beat_buf;
                    if (span) begin
                        state_d = LA_B1;
                    end else begin
                        state_d = LA_DONE;
                        res_d   = ext_res;
                        err_d   = 1'b0;
                    end
                end
            end
            LA_B1: begin
                sel_o  = mask[63:32];
                beat_o = 1'b1;
                if (ack_i) begin
                    lbuf_d  = beat_buf;
                    state_d = LA_DONE;
                    res_d   = ext_res;
                    err_d   = 1'b0;
                end
            end
            LA_DONE: begin
                res_v_o = 1'b1;
                if (res_rdy_i) begin
                    state_d = LA_IDLE;
                end
            end
            default: state_d = LA_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= LA_IDLE;
            func_q  <= '0;
            adr_q   <= '0;
            lbuf_q  <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            func_q  <= func_d;
            adr_q   <= adr_d;
            lbuf_q  <= lbuf_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    assign res_o = res_q;
    assign err_o = err_q;

endmodule

// File: tb/tb_any1_load_align.sv
// Directed bench for any1_load_align: byte-level reference model plus a
// per-cycle compare of the handshake, lane-select and result outputs.
module tb_any1_load_align;

    logic         clk = 1'b0;
    logic         rst;
    logic         req;
    logic         rdy;
    logic [3:0]   func;
    logic [4:0]   adr;
    logic [31:0]  sel;
    logic         beat;
    logic         ack;
    logic [255:0] dat;
    logic [255:0] res;
    logic         res_v;
    logic         res_rdy;
    logic         err;

    any1_load_align dut (
        .rst_i     (rst),
        .clk_i     (clk),
        .req_i     (req),
        .rdy_o     (rdy),
        .func_i    (func),
        .adr_i     (adr),
        .sel_o     (sel),
        .beat_o    (beat),
        .ack_i     (ack),
        .dat_i     (dat),
        .res_o     (res),
        .res_v_o   (res_v),
        .res_rdy_i (res_rdy),
        .err_o     (err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc++;

    logic         chk_en;
    logic         exp_rdy, exp_beat, exp_resv, exp_err;
    logic [31:0]  exp_sel;
    logic [255:0] exp_res;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Reference model: plain byte arithmetic over a 64-byte window.
    function automatic int m_size(input logic [3:0] f);
        case (f[2:0])
            3'd0: return 2;
            3'd1: return 4;
            3'd2: return 8;
            3'd3: return 16;
            3'd4: return 32;
            3'd5: return 0;
            default: return 16;
        endcase
    endfunction

    function automatic logic [31:0] m_sel(input logic [3:0] f, input logic [4:0] a, input int bt);
        logic [31:0] s;
        int idx;
        s = '0;
        for (int i = 0; i < 32; i++) begin
            idx = bt * 32 + i;
            s[i] = (idx >= int'(a)) && (idx < int'(a) + m_size(f));
        end
        return s;
    endfunction

    function automatic logic [255:0] m_res(input logic [3:0] f, input logic [4:0] a,
                                           input logic [255:0] d0, input logic [255:0] d1);
        logic [7:0]   by [64];
        logic [255:0] r;
        int n;
        for (int i = 0; i < 32; i++) begin
            by[i]      = d0[i*8 +: 8];
            by[i + 32] = d1[i*8 +: 8];
        end
        n = m_size(f);
        r = '0;
        for (int i = 0; i < n; i++) r[i*8 +: 8] = by[int'(a) + i];
        if (n > 0 && n < 32 && !f[3] && by[int'(a) + n - 1][7]) begin
            for (int i = n; i < 32; i++) r[i*8 +: 8] = 8'hFF;
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("rdy_o", {255'd0, rdy}, {255'd0, exp_rdy});
            chk("sel_o", {224'd0, sel}, {224'd0, exp_sel});
            chk("beat_o", {255'd0, beat}, {255'd0, exp_beat});
            chk("res_v_o", {255'd0, res_v}, {255'd0, exp_resv});
            if (exp_resv) begin
                chk("res_o", res, exp_res);
                chk("err_o", {255'd0, err}, {255'd0, exp_err});
            end
        end
    end

    task automatic set_idle();
        exp_rdy = 1'b1; exp_sel = '0; exp_beat = 1'b0; exp_resv = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete load: ack_gap idle cycles before each ack, bp cycles of
    // backpressure in DONE; hold_req keeps req high through DONE and beyond.
    task automatic run_load(input logic [3:0] f, input logic [4:0] a,
                            input logic [255:0] d0, input logic [255:0] d1,
                            input int ack_gap, input int bp, input bit hold_req,
                            input int turn_exp);
        int sz, t0;
        bit sp;
        sz = m_size(f);
        sp = (int'(a) + sz) > 32;
        req = 1'b1; func = f; adr = a;
        set_idle();
        step();
        t0 = cyc;
        req = 1'b0;
        exp_rdy = 1'b0;
        if (sz != 0) begin
            exp_sel = m_sel(f, a, 0); exp_beat = 1'b0;
            for (int i = 0; i < ack_gap; i++) step();
            ack = 1'b1; dat = d0;
            step();
            if (sp) begin
                exp_sel = m_sel(f, a, 1); exp_beat = 1'b1;
                ack = 1'b0;
                for (int i = 0; i < ack_gap; i++) step();
                ack = 1'b1; dat = d1;
                step();
            end
            ack = 1'b0; dat = '1;
        end
        exp_sel = '0; exp_beat = 1'b0; exp_resv = 1'b1;
        exp_res = m_res(f, a, d0, d1); exp_err = (sz == 0);
        if (hold_req) req = 1'b1;
        res_rdy = (bp == 0);
        for (int i = 0; i < bp; i++) step();
        res_rdy = 1'b1;
        step();
        res_rdy = 1'b0;
        set_idle();
        if (turn_exp != 0) chk("turnaround", 256'(cyc - t0 + 1), 256'(turn_exp));
    endtask

    logic [255:0] d0, d1;

    initial begin
        chk_en = 1'b0;
        rst = 1'b1; req = 1'b0; func = '0; adr = '0; ack = 1'b0; dat = '0; res_rdy = 1'b0;
        exp_res = '0; exp_err = 1'b0;
        set_idle();

        // Hand-computed pins on the reference model.
        chk("m_res byte-pair", m_res(4'd0, 5'd0, {240'h0, 16'h8001}, '0), {{240{1'b1}}, 16'h8001});
        chk("m_sel octa", {224'd0, m_sel(4'd10, 5'd8, 0)}, {224'd0, 32'h0000_FF00});
        chk("m_sel span b0", {224'd0, m_sel(4'd3, 5'd24, 0)}, {224'd0, 32'hFF00_0000});
        chk("m_sel span b1", {224'd0, m_sel(4'd3, 5'd24, 1)}, {224'd0, 32'h0000_00FF});
        chk("m_res span", m_res(4'd3, 5'd24, {64'h0123_4567_89AB_CDEF, 192'h0}, {192'h0, 64'h8877_6655_4433_2211}),
            {{128{1'b1}}, 64'h8877_6655_4433_2211, 64'h0123_4567_89AB_CDEF});
        chk("m_res illegal", m_res(4'd5, 5'd3, '1, '1), 256'h0);

        step();
        chk("reset res_o", res, 256'h0);
        chk("reset err_o", {255'd0, err}, 256'h0);
        chk_en = 1'b1;
        step();
        rst = 1'b0;
        step();

        // Aligned signed byte-pair.
        d0 = {{15{16'hAAAA}}, 16'h8001};
        run_load(4'd0, 5'd0, d0, '0, 0, 0, 0, 3);
        chk("byte-pair literal", res, {{240{1'b1}}, 16'h8001});

        // Unsigned octa at offset 8.
        d0 = {128'h1234_5678_9ABC_DEF0_1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210, 64'h1111_2222_3333_4444};
        run_load(4'd10, 5'd8, d0, '0, 1, 0, 0, 0);
        chk("octa literal", res, {192'h0, 64'hFEDC_BA98_7654_3210});

        // Spanning 16 B, ack held across both beats.
        d0 = {64'h0123_4567_89AB_CDEF, 192'h5A5A};
        d1 = {192'hC3C3, 64'h8877_6655_4433_2211};
        run_load(4'd3, 5'd24, d0, d1, 0, 0, 0, 4);
        chk("span literal", res, {{128{1'b1}}, 64'h8877_6655_4433_2211, 64'h0123_4567_89AB_CDEF});

        // Illegal func code.
        run_load(4'd5, 5'd7, '1, '1, 0, 0, 0, 0);
        run_load(4'd13, 5'd0, '1, '1, 0, 2, 0, 0);

        // Backpressure with req held through DONE; next load follows immediately.
        d0 = {16'h80FF, {15{16'h0102}}};
        d1 = {{15{16'h7777}}, 16'h0380};
        run_load(4'd1, 5'd30, d0, d1, 0, 5, 1, 0);
        run_load(4'd4, 5'd0, d1, d0, 0, 0, 0, 0);

        // Remaining size codes and extension modes.
        d0 = {32{8'h9C}} ^ {8{32'h0F1E_2D3C}};
        d1 = {32{8'hE1}} ^ {8{32'h4B5A_6978}};
        run_load(4'd12, 5'd16, d0, d1, 0, 0, 0, 4);
        run_load(4'd6, 5'd5, d0, d1, 2, 1, 0, 0);
        run_load(4'd15, 5'd17, d0, d1, 1, 0, 0, 0);
        run_load(4'd7, 5'd17, d0, d1, 0, 0, 0, 0);
        run_load(4'd2, 5'd28, d0, d1, 2, 0, 0, 0);
        run_load(4'd9, 5'd31, d0, d1, 0, 0, 0, 0);

        // Reset asserted while waiting on the second beat.
        req = 1'b1; func = 4'd3; adr = 5'd24;
        step();
        req = 1'b0; exp_rdy = 1'b0; exp_sel = m_sel(4'd3, 5'd24, 0);
        ack = 1'b1; dat = '1;
        step();
        ack = 1'b0; exp_sel = m_sel(4'd3, 5'd24, 1); exp_beat = 1'b1;
        #2;
        rst = 1'b1;
        set_idle();
        #1;
        chk("rst rdy_o", {255'd0, rdy}, {255'd0, 1'b1});
        chk("rst sel_o", {224'd0, sel}, 256'h0);
        chk("rst beat_o", {255'd0, beat}, 256'h0);
        chk("rst res_v_o", {255'd0, res_v}, 256'h0);
        chk("rst res_o", res, 256'h0);
        chk("rst err_o", {255'd0, err}, 256'h0);
        step();
        rst = 1'b0;
        step();
        d0 = {{28{8'h33}}, 32'hF00D_8765};
        run_load(4'd1, 5'd0, d0, '0, 0, 0, 0, 3);
        chk("post-reset literal", res, {{224{1'b1}}, 32'hF00D_8765});

        step();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
